player_shots_multi: RTL and testbench
=====================================

PLAYER_SHOTS_MULTI -- requirements
Module: player_shots_multi

Interface
REQ-001 SHALL have parameter NUM_SHOTS, default 3, number of independent shot slots (1..8).
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 8, frames between accepted launches (0 = none).
REQ-003 SHALL have parameter INITIAL_Y, default 400, launch Y in pixels.
REQ-004 SHALL have parameter Y_SPEED, default -320, per-frame Y step in 1/64-pixel units.
REQ-005 SHALL have parameter X_OFFSET, default 32, launch X offset from playerXPosition in pixels.
REQ-006 SHALL have parameter TOP_LIMIT, default 0, pixel Y below which a shot retires.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port startOfFrame, input, 1, one-clock pulse per frame.
REQ-010 SHALL have port playGame, input, 1, game active; low clears all shots.
REQ-011 SHALL have port fireReq, input, 1, fire button level.
REQ-012 SHALL have port playerXPosition, input, 11 signed, player top-left X in pixels.
REQ-013 SHALL have port hitVec, input, NUM_SHOTS, per-slot collision pulse.
REQ-014 SHALL have port topLeftX, output, NUM_SHOTS x 11 signed, per-slot X in pixels.
REQ-015 SHALL have port topLeftY, output, NUM_SHOTS x 11 signed, per-slot Y in pixels.
REQ-016 SHALL have port aliveVec, output, NUM_SHOTS, per-slot in-flight flag.
REQ-017 SHALL have port shotFired, output, 1, one-clock pulse per accepted launch.
REQ-018 SHALL have port activeCount, output, 4, number of set aliveVec bits.

Function
REQ-019 Positions SHALL be held as 32-bit signed fixed point, 6 fractional bits; pixel outputs SHALL be bits [16:6].
REQ-020 Each slot SHALL be in one of two states: IDLE (alive 0) or FLY (alive 1).
REQ-021 fireReq SHALL be edge-detected through one register; a launch request is fireReq=1 with the registered copy at 0.
REQ-022 A request SHALL be accepted only if cooldown counter is 0, playGame is 1, and at least one slot is IDLE.
REQ-023 On acceptance, the lowest-index IDLE slot SHALL enter FLY on the next clock, with X=(playerXPosition+X_OFFSET)*64 and Y=INITIAL_Y*64; shotFired SHALL pulse in that same cycle.
REQ-024 On acceptance, cooldown SHALL load COOLDOWN_FRAMES and decrement by 1 on each startOfFrame, saturating at 0.
REQ-025 Rejected requests SHALL be dropped, not queued.
REQ-026 On startOfFrame, each FLY slot SHALL add Y_SPEED to Y; X is unchanged.
REQ-027 A FLY slot whose pixel Y after the update is less than TOP_LIMIT SHALL go IDLE on that same edge.
REQ-028 hitVec[i]=1 SHALL force slot i IDLE on the next edge and take priority over movement in the same cycle.
REQ-029 An IDLE slot SHALL hold its last position.
REQ-030 A slot retiring in cycle k SHALL NOT be launch-eligible until cycle k+1.
REQ-031 A launch coinciding with startOfFrame SHALL load initial position without applying that frame's step.
REQ-032 hitVec on an IDLE slot SHALL be ignored.
REQ-033 activeCount SHALL be combinational popcount of aliveVec.

Reset
REQ-034 resetN low SHALL asynchronously set all slots IDLE, positions X=0 and Y=INITIAL_Y*64, cooldown 0, edge register 0, and shotFired 0.
REQ-035 playGame low SHALL synchronously apply the same values as REQ-034; mid-flight shots SHALL vanish on the next edge.

Structure
REQ-036 Package space_inv_pkg SHALL hold COORD_W=11, FRAC_BITS=6, the coord_t typedef, and the shared screen constants.
REQ-037 One sub-module, player_shot_slot, SHALL implement the per-slot state, position, and retire logic; the top level SHALL generate NUM_SHOTS instances plus arbitration and cooldown.

Verification
REQ-038 Scenario: playerX=100, a fireReq edge -> next cycle shotFired=1, aliveVec=001, X=132, Y=400; after 10 frames Y=350.
REQ-039 Scenario: single shot, no hit -> Y=5 after frame 79; slot goes IDLE at frame 81 (Y would be -5).
REQ-040 Scenario: fire edges at frames 0, 4, 8, 16 with COOLDOWN_FRAMES=8 -> accepted at 0, 8, 16; slots 0, 1, 2 in order.
REQ-041 Scenario: all 3 slots FLY, new fire edge after cooldown -> rejected, no shotFired; hitVec=010 -> slot 1 IDLE; next edge launches slot 1.
REQ-042 Scenario: hitVec[0] coincident with startOfFrame -> slot 0 IDLE, Y unchanged from the prior frame.
REQ-043 Scenario: playGame low mid-flight -> aliveVec=000, Y=400, cooldown 0 next cycle; a resetN pulse gives the same values asynchronously.

Source files
------------

// File: rtl/space_inv_pkg.sv
// Shared types and constants for the space-invaders game blocks.
// Fixed-point positions carry 6 fractional bits; pixel coords are 11-bit signed.
package space_inv_pkg;

  localparam int COORD_W   = 11;
  localparam int FRAC_BITS = 6;
  localparam int FIX_W     = 32;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [FIX_W-1:0]   fix_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_t;

  function automatic fix_t px_to_fix(input int px);
    return fix_t'(px) <<< FRAC_BITS;
  endfunction

  function automatic coord_t fix_to_px(input fix_t v);
    return coord_t'(v[FRAC_BITS+COORD_W-1:FRAC_BITS]);
  endfunction

endpackage

// File: rtl/player_shot_slot.sv
// One shot slot: IDLE/FLY state, fixed-point position and retire logic.
// A hit beats movement; an idle slot ignores hits and keeps its position.
module player_shot_slot
  import space_inv_pkg::*;
#(
  parameter int INITIAL_Y = 400,
  parameter int Y_SPEED   = -320,
  parameter int TOP_LIMIT = 0
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear_i,
  input  logic sof_i,
  input  logic launch_i,
  input  logic hit_i,
  input  fix_t launch_x_i,
  output logic alive_o,
  output fix_t x_o,
  output fix_t y_o
);

  localparam fix_t   Y_INIT = px_to_fix(INITIAL_Y);
  localparam fix_t   Y_STEP = fix_t'(Y_SPEED);
  localparam coord_t TOP_PX = coord_t'(TOP_LIMIT);

  slot_state_t state_q, state_d;
  fix_t        x_q, x_d;
  fix_t        y_q, y_d;
  fix_t        y_step;

  assign y_step = y_q + Y_STEP;

  // State and position registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= Y_INIT;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next state: clear, launch, hit, per-frame step and top-edge retire
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (clear_i) begin
      state_d = SLOT_IDLE;
      x_d     = '0;
      y_d     = Y_INIT;
    end else begin
      unique case (state_q)
        SLOT_IDLE: begin
          if (launch_i) begin
            state_d = SLOT_FLY;
            x_d     = launch_x_i;
            y_d     = Y_INIT;
          end
        end
        SLOT_FLY: begin
          if (hit_i) begin
            state_d = SLOT_IDLE;
          end else if (sof_i) begin
            y_d = y_step;
            if (fix_to_px(y_step) < TOP_PX)
              state_d = SLOT_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    alive_o = (state_q == SLOT_FLY);
    x_o     = x_q;
    y_o     = y_q;
  end

endmodule

// File: rtl/player_shots_multi.sv
// Multi-slot player shots: fire edge detect, cooldown, lowest-idle arbitration.
// Each slot moves and retires on its own; activeCount is a live popcount.
module player_shots_multi
  import space_inv_pkg::*;
#(
  parameter int NUM_SHOTS       = 3,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int INITIAL_Y       = 400,
  parameter int Y_SPEED         = -320,
  parameter int X_OFFSET        = 32,
  parameter int TOP_LIMIT       = 0
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         playGame,
  input  logic                         fireReq,
  input  coord_t                       playerXPosition,
  input  logic   [NUM_SHOTS-1:0]       hitVec,
  output coord_t [NUM_SHOTS-1:0]       topLeftX,
  output coord_t [NUM_SHOTS-1:0]       topLeftY,
  output logic   [NUM_SHOTS-1:0]       aliveVec,
  output logic                         shotFired,
  output logic   [3:0]                 activeCount
);

  localparam int CD_W = 16;

  logic                 fire_q, fire_d;
  logic                 fired_q, fired_d;
  logic [CD_W-1:0]      cool_q, cool_d;
  logic                 fire_req;
  logic                 accept;
  logic [NUM_SHOTS-1:0] idle_vec;
  logic [NUM_SHOTS-1:0] grant;
  fix_t                 launch_x;
  fix_t                 x_fix [NUM_SHOTS];
  fix_t                 y_fix [NUM_SHOTS];

  assign fire_req = fireReq & ~fire_q;
  assign idle_vec = ~aliveVec;
  assign grant    = idle_vec & (~idle_vec + NUM_SHOTS'(1));
  assign accept   = fire_req && (cool_q == '0) && playGame && (|idle_vec);
  assign launch_x = (fix_t'(playerXPosition) + fix_t'(X_OFFSET)) <<< FRAC_BITS;

  // Next values for edge register, launch pulse and cooldown
  always_comb begin
    fire_d  = playGame ? fireReq : 1'b0;
    fired_d = accept;
    cool_d  = cool_q;
    if (!playGame)
      cool_d = '0;
    else if (accept)
      cool_d = CD_W'(COOLDOWN_FRAMES);
    else if (startOfFrame && (cool_q != '0))
      cool_d = cool_q - CD_W'(1);
  end

  // Control registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_q  <= 1'b0;
      fired_q <= 1'b0;
      cool_q  <= '0;
    end else begin
      fire_q  <= fire_d;
      fired_q <= fired_d;
      cool_q  <= cool_d;
    end
  end

  assign shotFired = fired_q;

  for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
    player_shot_slot #(
      .INITIAL_Y (INITIAL_Y),
      .Y_SPEED   (Y_SPEED),
      .TOP_LIMIT (TOP_LIMIT)
    ) u_slot (
      .clk        (clk),
      .resetN     (resetN),
      .clear_i    (~playGame),
      .sof_i      (startOfFrame),
      .launch_i   (accept & grant[i]),
      .hit_i      (hitVec[i]),
      .launch_x_i (launch_x),
      .alive_o    (aliveVec[i]),
      .x_o        (x_fix[i]),
      .y_o        (y_fix[i])
    );
    assign topLeftX[i] = fix_to_px(x_fix[i]);
    assign topLeftY[i] = fix_to_px(y_fix[i]);
  end

  // Popcount of live slots
  always_comb begin
    activeCount = '0;
    for (int i = 0; i < NUM_SHOTS; i++)
      activeCount = activeCount + 4'(aliveVec[i]);
  end

endmodule

// File: tb/tb_player_shots_multi.sv
// Bench for player_shots_multi: launch scoreboard plus a pixel-level model.
// Scenario tasks run in sequence from one initial block.
module tb_player_shots_multi;
  import space_inv_pkg::*;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             startOfFrame = 1'b0;
  logic             playGame = 1'b0;
  logic             fireReq = 1'b0;
  coord_t           playerXPosition = '0;
  logic   [N-1:0]   hitVec = '0;
  coord_t [N-1:0]   topLeftX;
  coord_t [N-1:0]   topLeftY;
  logic   [N-1:0]   aliveVec;
  logic             shotFired;
  logic   [3:0]     activeCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int slot;
    int x;
    int y;
  } launch_t;

  launch_t sb[$];
  int mdl_alive [N];
  int mdl_x [N];
  int mdl_y [N];

  always #5 clk = ~clk;

  player_shots_multi dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .playGame        (playGame),
    .fireReq         (fireReq),
    .playerXPosition (playerXPosition),
    .hitVec          (hitVec),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .aliveVec        (aliveVec),
    .shotFired       (shotFired),
    .activeCount     (activeCount)
  );

  // Scoreboard: every shotFired pulse must match a queued launch
  always @(negedge clk) begin
    if (resetN && shotFired) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_shot got shotFired=1 want 0");
      end else begin
        launch_t e;
        e = sb.pop_front();
        if (aliveVec[e.slot] !== 1'b1 ||
            topLeftX[e.slot] !== coord_t'(e.x) ||
            topLeftY[e.slot] !== coord_t'(e.y)) begin
          errors++;
          $display("FAIL launch_slot%0d got alive=%b x=%0d y=%0d want 1 x=%0d y=%0d",
                   e.slot, aliveVec[e.slot], $signed(topLeftX[e.slot]),
                   $signed(topLeftY[e.slot]), e.x, e.y);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < N; i++) begin
      mdl_alive[i] = 0;
      mdl_x[i] = 0;
      mdl_y[i] = 400;
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mdl_alive[i] != 0) begin
        mdl_y[i] = mdl_y[i] - 5;
        if (mdl_y[i] < 0) mdl_alive[i] = 0;
      end
    end
    tick();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  // slot < 0 means the request must be rejected
  task automatic fire(input int slot, input int px, input logic [N-1:0] hv);
    launch_t e;
    playerXPosition = coord_t'(px);
    hitVec = hv;
    fireReq = 1'b1;
    if (slot >= 0) begin
      e.slot = slot;
      e.x = px + 32;
      e.y = 400;
      sb.push_back(e);
    end
    tick();
    for (int i = 0; i < N; i++)
      if (hv[i]) mdl_alive[i] = 0;
    if (slot >= 0) begin
      mdl_alive[slot] = 1;
      mdl_x[slot] = px + 32;
      mdl_y[slot] = 400;
    end
    fireReq = 1'b0;
    hitVec = '0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL launch_missing got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    playGame = 1'b1;
    mdl_clear();
    tick();
    tick();
    checks++;
    if (aliveVec !== 3'b000 || shotFired !== 1'b0 || activeCount !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags got alive=%b fired=%b cnt=%0d want 000 0 0",
               aliveVec, shotFired, activeCount);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (topLeftX[i] !== coord_t'(0) || topLeftY[i] !== coord_t'(400)) begin
        errors++;
        $display("FAIL reset_pos%0d got x=%0d y=%0d want 0 400",
                 i, $signed(topLeftX[i]), $signed(topLeftY[i]));
      end
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_launch();
    fire(0, 100, 3'b000);
    checks++;
    if (aliveVec !== 3'b001 || activeCount !== 4'd1) begin
      errors++;
      $display("FAIL launch_alive got alive=%b cnt=%0d want 001 1", aliveVec, activeCount);
    end
    frames(10);
    checks++;
    if (topLeftY[0] !== coord_t'(350) || topLeftX[0] !== coord_t'(132)) begin
      errors++;
      $display("FAIL move_10 got x=%0d y=%0d want 132 350",
               $signed(topLeftX[0]), $signed(topLeftY[0]));
    end
  endtask

  task automatic test_retire();
    frames(69);
    checks++;
    if (topLeftY[0] !== coord_t'(5) || aliveVec !== 3'b001) begin
      errors++;
      $display("FAIL frame79 got y=%0d alive=%b want 5 001", $signed(topLeftY[0]), aliveVec);
    end
    frame();
    checks++;
    if (topLeftY[0] !== coord_t'(0) || aliveVec !== 3'b001) begin
      errors++;
      $display("FAIL frame80 got y=%0d alive=%b want 0 001", $signed(topLeftY[0]), aliveVec);
    end
    frame();
    checks++;
    if (topLeftY[0] !== coord_t'(-5) || aliveVec !== 3'b000 || activeCount !== 4'd0) begin
      errors++;
      $display("FAIL frame81 got y=%0d alive=%b cnt=%0d want -5 000 0",
               $signed(topLeftY[0]), aliveVec, activeCount);
    end
  endtask

  task automatic test_cooldown();
    fire(0, 10, 3'b000);
    frames(4);
    fire(-1, 10, 3'b000);
    checks++;
    if (aliveVec !== 3'b001) begin
      errors++;
      $display("FAIL cooldown_f4 got alive=%b want 001", aliveVec);
    end
    frames(4);
    fire(1, 20, 3'b000);
    frames(4);
    fire(-1, 0, 3'b000);
    frames(4);
    fire(2, -20, 3'b000);
    checks++;
    if (aliveVec !== 3'b111 || activeCount !== 4'd3) begin
      errors++;
      $display("FAIL cooldown_f16 got alive=%b cnt=%0d want 111 3", aliveVec, activeCount);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (topLeftX[i] !== coord_t'(mdl_x[i]) || topLeftY[i] !== coord_t'(mdl_y[i])) begin
        errors++;
        $display("FAIL cooldown_pos%0d got x=%0d y=%0d want %0d %0d", i,
                 $signed(topLeftX[i]), $signed(topLeftY[i]), mdl_x[i], mdl_y[i]);
      end
    end
  endtask

  task automatic test_full();
    frames(8);
    fire(-1, 0, 3'b000);
    checks++;
    if (aliveVec !== 3'b111) begin
      errors++;
      $display("FAIL full_reject got alive=%b want 111", aliveVec);
    end
    hitVec = 3'b010;
    tick();
    hitVec = '0;
    mdl_alive[1] = 0;
    checks++;
    if (aliveVec !== 3'b101 || activeCount !== 4'd2 ||
        topLeftY[1] !== coord_t'(mdl_y[1])) begin
      errors++;
      $display("FAIL hit_slot1 got alive=%b cnt=%0d y=%0d want 101 2 %0d",
               aliveVec, activeCount, $signed(topLeftY[1]), mdl_y[1]);
    end
    fire(1, 50, 3'b010);
    checks++;
    if (aliveVec !== 3'b111) begin
      errors++;
      $display("FAIL relaunch_slot1 got alive=%b want 111", aliveVec);
    end
  endtask

  task automatic test_hit_sof();
    frames(2);
    hitVec = 3'b001;
    startOfFrame = 1'b1;
    tick();
    hitVec = '0;
    startOfFrame = 1'b0;
    mdl_alive[0] = 0;
    for (int i = 1; i < N; i++) begin
      if (mdl_alive[i] != 0) mdl_y[i] = mdl_y[i] - 5;
    end
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (aliveVec[i] !== mdl_alive[i][0] || topLeftY[i] !== coord_t'(mdl_y[i])) begin
        errors++;
        $display("FAIL hit_sof%0d got alive=%b y=%0d want %0d %0d", i,
                 aliveVec[i], $signed(topLeftY[i]), mdl_alive[i], mdl_y[i]);
      end
    end
  endtask

  task automatic test_playgame();
    playGame = 1'b0;
    tick();
    mdl_clear();
    checks++;
    if (aliveVec !== 3'b000 || activeCount !== 4'd0) begin
      errors++;
      $display("FAIL pg_low got alive=%b cnt=%0d want 000 0", aliveVec, activeCount);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (topLeftX[i] !== coord_t'(0) || topLeftY[i] !== coord_t'(400)) begin
        errors++;
        $display("FAIL pg_pos%0d got x=%0d y=%0d want 0 400",
                 i, $signed(topLeftX[i]), $signed(topLeftY[i]));
      end
    end
    fire(-1, 30, 3'b000);
    playGame = 1'b1;
    tick();
    fire(0, 30, 3'b000);
    checks++;
    if (aliveVec !== 3'b001) begin
      errors++;
      $display("FAIL pg_cool_clear got alive=%b want 001", aliveVec);
    end
    resetN = 1'b0;
    #2;
    mdl_clear();
    checks++;
    if (aliveVec !== 3'b000 || shotFired !== 1'b0 ||
        topLeftY[0] !== coord_t'(400) || topLeftX[0] !== coord_t'(0)) begin
      errors++;
      $display("FAIL async_reset got alive=%b fired=%b x=%0d y=%0d want 000 0 0 400",
               aliveVec, shotFired, $signed(topLeftX[0]), $signed(topLeftY[0]));
    end
    #2;
    resetN = 1'b1;
    tick();
    fire(0, 0, 3'b000);
    checks++;
    if (aliveVec !== 3'b001) begin
      errors++;
      $display("FAIL post_reset_fire got alive=%b want 001", aliveVec);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_retire();
    test_cooldown();
    test_full();
    test_hit_sof();
    test_playgame();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
